// File: rtl/ad_frame_avg.sv
// Frame averager behind the AD7606 capture FIFO: drains one CHANNELS-word frame at a time,
// sums 2^AVG_SHIFT frames per channel and streams out the floored per-channel averages.
module ad_frame_avg #(
  parameter int CHANNELS  = 8,
  parameter int AVG_SHIFT = 3,
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_W-1:0]     data_cnt,
  input  logic [DATA_W-1:0]    ad_data,
  output logic                 ad_rd,
  output logic [DATA_W-1:0]    avg_data,
  output logic [2:0]           avg_ch,
  output logic                 avg_valid,
  input  logic                 avg_ready,
  output logic                 avg_last,
  output logic [AVG_SHIFT-1:0] frame_idx
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ACC_W = DATA_W + AVG_SHIFT;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] TAIL = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(CHANNELS - 1);
  localparam logic [AVG_SHIFT-1:0] LAST_FRAME  = '1;
  localparam logic [CNT_W-1:0]     FRAME_WORDS = CNT_W'(CHANNELS);

  logic [1:0]           state_reg;
  logic [IDX_W-1:0]     rd_idx_reg;
  logic [IDX_W-1:0]     out_idx_reg;
  logic [IDX_W-1:0]     cap_idx_reg;
  logic                 cap_valid_reg;
  logic [1:0]           guard_reg;
  logic [AVG_SHIFT-1:0] frame_idx_reg;

  logic [CHANNELS*ACC_W-1:0] acc_flat;
  logic signed [ACC_W-1:0]   sample_ext;
  logic signed [ACC_W-1:0]   acc_sel;
  logic signed [ACC_W-1:0]   acc_shift;
  logic                      acc_frac_unused;

  assign ad_rd = (state_reg == READ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      rd_idx_reg    <= '0;
      out_idx_reg   <= '0;
      guard_reg     <= '0;
      frame_idx_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // guard hides the few cycles rdusedw needs to reflect the last burst
          if (guard_reg != 2'd0) begin
            guard_reg <= guard_reg - 2'd1;
          end else if (data_cnt >= FRAME_WORDS) begin
            state_reg  <= READ;
            rd_idx_reg <= '0;
          end
        end
        READ: begin
          if (rd_idx_reg == LAST_IDX) state_reg <= TAIL;
          else                        rd_idx_reg <= rd_idx_reg + 1'b1;
        end
        TAIL: begin
          if (frame_idx_reg == LAST_FRAME) begin
            frame_idx_reg <= '0;
            out_idx_reg   <= '0;
            state_reg     <= OUT;
          end else begin
            frame_idx_reg <= frame_idx_reg + 1'b1;
            guard_reg     <= 2'd2;
            state_reg     <= IDLE;
          end
        end
        OUT: begin
          if (avg_ready) begin
            if (out_idx_reg == LAST_IDX) begin
              guard_reg <= 2'd2;
              state_reg <= IDLE;
            end else begin
              out_idx_reg <= out_idx_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Non-showahead FIFO: the word requested in one cycle appears on ad_data the next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_valid_reg <= 1'b0;
      cap_idx_reg   <= '0;
    end else begin
      cap_valid_reg <= ad_rd;
      cap_idx_reg   <= rd_idx_reg;
    end
  end

  assign sample_ext = {{AVG_SHIFT{ad_data[DATA_W-1]}}, ad_data};

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_acc
      logic signed [ACC_W-1:0] acc_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          acc_reg <= '0;
        end else if (cap_valid_reg && (cap_idx_reg == IDX_W'(gi))) begin
          // first frame of a block overwrites, so stale or aborted sums never leak in
          if (frame_idx_reg == '0) acc_reg <= sample_ext;
          else                     acc_reg <= acc_reg + sample_ext;
        end
      end

      assign acc_flat[gi*ACC_W +: ACC_W] = acc_reg;
    end
  endgenerate

  assign acc_sel         = acc_flat[out_idx_reg*ACC_W +: ACC_W];
  assign acc_shift       = acc_sel >>> AVG_SHIFT;
  assign acc_frac_unused = ^acc_shift[ACC_W-1:DATA_W];

  assign avg_data  = acc_shift[DATA_W-1:0];
  assign avg_ch    = 3'(out_idx_reg);
  assign avg_valid = (state_reg == OUT);
  assign avg_last  = avg_valid && (out_idx_reg == LAST_IDX);
  assign frame_idx = frame_idx_reg;

endmodule

// File: tb/tb_ad_frame_avg.sv
// Randomized bench for ad_frame_avg: a queue-based FIFO model feeds frames and a
// block-level floor-average model predicts every output handshake.
module tb_ad_frame_avg;

  localparam int CH = 8;
  localparam int SH = 3;
  localparam int DW = 16;
  localparam int CW = 5;
  localparam int NF = 1 << SH;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] data_cnt = '0;
  logic [DW-1:0] ad_data = '0;
  logic          ad_rd;
  logic [DW-1:0] avg_data;
  logic [2:0]    avg_ch;
  logic          avg_valid;
  logic          avg_ready = 1'b1;
  logic          avg_last;
  logic [SH-1:0] frame_idx;

  always #5 clk = ~clk;

  ad_frame_avg #(.CHANNELS(CH), .AVG_SHIFT(SH), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_cnt  (data_cnt),
    .ad_data   (ad_data),
    .ad_rd     (ad_rd),
    .avg_data  (avg_data),
    .avg_ch    (avg_ch),
    .avg_valid (avg_valid),
    .avg_ready (avg_ready),
    .avg_last  (avg_last),
    .frame_idx (frame_idx)
  );

  typedef struct packed {
    logic [2:0]    ch;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] fifo_q[$];
  int cmp_cnt = 0;
  int err_cnt = 0;
  int hs_cnt  = 0;
  int hs_exp  = 0;
  logic rd_pend = 1'b0;
  int run_len = 0;
  int gap_len = 0;
  bit first_burst = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    cmp_cnt++;
    if (obs !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // FIFO model: a request seen in one cycle delivers the head word just after the next edge.
  always @(posedge clk) begin
    #1;
    if (rd_pend && fifo_q.size() > 0) ad_data = fifo_q.pop_front();
    data_cnt = (fifo_q.size() > 31) ? 5'd31 : CW'(fifo_q.size());
  end

  always @(negedge clk) begin
    exp_t e;
    rd_pend = ad_rd;
    if (reset) begin
      run_len = 0;
      gap_len = 0;
      first_burst = 1'b1;
    end else begin
      if (ad_rd) begin
        if (run_len == 0 && !first_burst) check("burst_gap_ge4", 32'(gap_len >= 4), 1);
        run_len++;
        gap_len = 0;
      end else begin
        if (run_len != 0) begin
          check("burst_len", run_len, CH);
          first_burst = 1'b0;
          run_len = 0;
        end
        gap_len++;
      end
      if (avg_valid && avg_ready) begin
        hs_cnt++;
        $display("out ch=%0d data=%h last=%0b", avg_ch, avg_data, avg_last);
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("avg_ch", avg_ch, e.ch);
          check("avg_data", avg_data, e.data);
          check("avg_last", avg_last, e.last);
        end
      end
    end
  end

  // mode 0: random, 1: channel c = c*100, 2: ch0 alternates -1/0, ch1 = -32768
  task automatic push_block(input int mode);
    int sums[CH];
    int v, s, a;
    logic signed [DW-1:0] r;
    for (int c = 0; c < CH; c++) sums[c] = 0;
    for (int f = 0; f < NF; f++) begin
      for (int c = 0; c < CH; c++) begin
        r = DW'($urandom);
        v = r;
        if (mode == 1) v = c * 100;
        if (mode == 2 && c == 0) v = (f % 2 == 0) ? -1 : 0;
        if (mode == 2 && c == 1) v = -32768;
        sums[c] += v;
        fifo_q.push_back(DW'(v));
      end
    end
    for (int c = 0; c < CH; c++) begin
      s = sums[c];
      a = (s >= 0) ? s / NF : -((-s + NF - 1) / NF);
      exp_q.push_back('{ch: 3'(c), data: DW'(a), last: (c == CH - 1)});
    end
    hs_exp += CH;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ad_rd"}, ad_rd, 0);
    check({tag, "_valid"}, avg_valid, 0);
    check({tag, "_last"}, avg_last, 0);
    check({tag, "_data"}, avg_data, 0);
    check({tag, "_ch"}, avg_ch, 0);
    check({tag, "_frame"}, frame_idx, 0);
  endtask

  initial begin
    int n, nrd, busy;

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // one word short of a frame: nothing may be read
    for (int i = 0; i < CH - 1; i++) fifo_q.push_back(DW'(i));
    busy = 0;
    repeat (100) begin
      @(negedge clk);
      if (ad_rd || avg_valid) busy++;
    end
    check("idle_short_frame", busy, 0);
    fifo_q.delete();
    repeat (3) @(negedge clk);

    push_block(1);
    wait_drain(2000);
    repeat (3) @(negedge clk);
    check("post_block_frame", frame_idx, 0);
    check("post_block_valid", avg_valid, 0);

    push_block(2);
    wait_drain(2000);

    // backpressure on channel 3 with the FIFO well stocked
    push_block(0);
    push_block(0);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(avg_valid && avg_ch == 3) && n < 3000);
    check("bp_reach_ch3", avg_ch, 3);
    avg_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", avg_valid, 1);
      check("bp_ch", avg_ch, 3);
      check("bp_data", avg_data, (exp_q.size() > 0) ? 32'(exp_q[0].data) : 32'hDEAD_BEEF);
      check("bp_no_rd", ad_rd, 0);
      check("bp_fifo_full", 32'(data_cnt >= 16), 1);
    end
    @(posedge clk);
    #2;
    avg_ready = 1'b1;
    wait_drain(3000);

    // random ready toggling
    push_block(0);
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge clk);
      #2;
      avg_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    @(posedge clk);
    #2;
    avg_ready = 1'b1;
    check("rand_ready_left", exp_q.size(), 0);

    // abort on the fifth read of frame 3
    push_block(0);
    nrd = 0;
    n = 0;
    while (nrd < 3 * CH + 5 && n < 3000) begin
      @(negedge clk);
      if (ad_rd) nrd++;
      n++;
    end
    check("abort_frame", frame_idx, 3);
    reset = 1'b1;
    #1;
    check_reset_outputs("abort");
    fifo_q.delete();
    exp_q.delete();
    hs_exp -= CH;
    @(negedge clk);
    reset = 1'b0;

    push_block(0);
    wait_drain(2000);
    repeat (5) @(negedge clk);
    check("handshake_total", hs_cnt, hs_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
